lpddr4_test_sequencer: RTL
==========================

# lpddr4_test_sequencer

Run controller sitting directly upstream of the LFSR memory checker. It drives the checker's start, seed and test-size inputs and steps it through a programmable number of write/read-compare passes, advancing the seed between passes. After each pass it collects done, fail and the per-DQ fail mask into sticky status for register readout. A watchdog covers a hung checker or AXI fabric.

## Interface
- ITER_W, 16, width of iteration, fail and first-fail counters
- TMO_W, 32, width of the watchdog counter and cfg_timeout
- axi_clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cfg_go  in  1  single-cycle pulse; starts a run; honoured only in IDLE
- cfg_abort  in  1  level; stops the run at the next safe point
- cfg_iterations  in  ITER_W  number of passes; 0 = run until abort
- cfg_seed  in  128  seed for pass 0
- cfg_seed_inc  in  32  added to the seed between passes
- cfg_test_size  in  32  passed to the checker unchanged
- cfg_lfsr_en  in  1  passed to the checker unchanged
- cfg_timeout  in  TMO_W  cycle limit per wait state; 0 = watchdog disabled
- chk_start  out  1  checker start level
- chk_seed  out  128  checker seed
- chk_test_size  out  32  checker test size
- chk_lfsr_en  out  1  checker LFSR enable
- chk_done  in  1  checker done level
- chk_fail  in  1  checker fail flag; valid while chk_done=1
- chk_dq_fail  in  32  checker per-DQ fail mask; valid while chk_done=1
- busy  out  1  high in every state except IDLE
- finished  out  1  sticky; set on entry to FINISH; cleared by cfg_go
- aborted  out  1  sticky; run ended by cfg_abort
- timeout_err  out  1  sticky; run ended by the watchdog
- iter_count  out  ITER_W  passes completed
- fail_count  out  ITER_W  failing passes; saturates at all-ones
- first_fail_iter  out  ITER_W  iter_count value at the first failing pass
- first_fail_valid  out  1  first_fail_iter holds a value
- dq_fail_accum  out  32  OR of chk_dq_fail over all passes

## Operation
- Reset: all outputs 0. The FSM is in IDLE.
- Accepting cfg_go in IDLE:
  - clears finished, aborted, timeout_err, iter_count, fail_count, first_fail_*, dq_fail_accum;
  - latches cfg_iterations, cfg_seed_inc and cfg_timeout;
  - loads chk_seed=cfg_seed, chk_test_size=cfg_test_size and chk_lfsr_en=cfg_lfsr_en;
  - moves to LOAD.
- LOAD (1 cycle): chk_start stays 0 so the seed is stable before start. Moves to RUN.
- RUN: chk_start=1. The state waits for chk_done=1, then moves to RESULT.
- RESULT (1 cycle), samples the checker outputs:
  - iter_count+1;
  - dq_fail_accum |= chk_dq_fail;
  - if chk_fail: fail_count+1 (saturating); if first_fail_valid=0, also load first_fail_iter with the pre-increment iter_count and set first_fail_valid;
  - moves to RELEASE.
- RELEASE: chk_start=0. The state waits for chk_done=0, then moves to DECIDE.
- DECIDE (1 cycle), checked in this priority order:
  - stop flag set, or cfg_abort=1 -> FINISH;
  - cfg_iterations≠0 and iter_count==cfg_iterations -> FINISH;
  - otherwise chk_seed += cfg_seed_inc (zero-extended, mod 2^128) and move to LOAD.
- FINISH (1 cycle): sets finished and moves to IDLE.
- Watchdog:
  - the counter clears on entry to RUN and on entry to RELEASE, and increments every cycle spent in those states;
  - reaching cfg_timeout (when cfg_timeout≠0) sets timeout_err and the stop flag, increments fail_count, and forces RELEASE;
  - a timeout during RELEASE goes straight to FINISH.
- Abort:
  - cfg_abort=1 in LOAD or RUN sets aborted and the stop flag and forces RELEASE, with chk_start dropped the next cycle;
  - in RESULT, RELEASE or DECIDE, abort is recorded and acted on in DECIDE;
  - aborted is set only if the run did not also finish by count in the same DECIDE. Count completion takes priority for the flag; the run stops either way.
- cfg_go outside IDLE is ignored. cfg_* changes mid-run have no effect except cfg_abort.
- Asserting rstn mid-run drops chk_start to 0 immediately. The checker then returns to its own IDLE through its start synchroniser.

## Timing
- cfg_go sampled at edge n: LOAD at n+1 and chk_start=1 from n+2.
- chk_done rising at edge m: RESULT at m+1, then chk_start=0 from m+2.
- chk_done falling at edge k: DECIDE at k+1, then LOAD at k+2 for a new pass.
- Minimum inter-pass gap is therefore 3 cycles plus the checker's 2-flop synchroniser latency.
- All outputs are registered; there are no combinational input-to-output paths.
- Status outputs are stable from FINISH until the next accepted cfg_go.
- iter_count wraps at 2^ITER_W only when cfg_iterations=0.

## Test plan
- Pass-through: cfg_iterations=3, cfg_seed_inc=1, mock checker asserts done 50 cycles after start with fail=0 -> three start pulses with chk_seed = seed, seed+1, seed+2; iter_count=3, fail_count=0, finished=1, busy=0.
- Failure capture: 4 passes, mock fails pass 2 only with dq_fail=0x0000_0100 -> fail_count=1, first_fail_iter=2, first_fail_valid=1, dq_fail_accum=0x100.
- Watchdog: cfg_timeout=100, mock never raises done -> chk_start drops after 100 cycles in RUN; timeout_err=1, fail_count=1, finished=1, iter_count=0.
- Abort: cfg_iterations=0, abort asserted during pass 5 RUN -> chk_start=0 the next cycle; aborted=1, iter_count=4, then IDLE.
- Seed wrap: cfg_seed=all-ones, cfg_seed_inc=2 -> second-pass chk_seed=128'h1.
- Reset mid-RUN: rstn low -> all outputs 0 and chk_start=0 asynchronously; a new cfg_go after release runs normally.

Source files
------------

// File: rtl/lpddr4_test_sequencer.sv
// Run controller for the LFSR memory checker: sequences write/read-compare passes,
// advances the seed between passes and accumulates sticky pass/fail status.
module lpddr4_test_sequencer #(
  parameter int unsigned ITER_W = 16,
  parameter int unsigned TMO_W  = 32
) (
  input  logic              axi_clk,
  input  logic              rstn,
  input  logic              cfg_go,
  input  logic              cfg_abort,
  input  logic [ITER_W-1:0] cfg_iterations,
  input  logic [127:0]      cfg_seed,
  input  logic [31:0]       cfg_seed_inc,
  input  logic [31:0]       cfg_test_size,
  input  logic              cfg_lfsr_en,
  input  logic [TMO_W-1:0]  cfg_timeout,
  output logic              chk_start,
  output logic [127:0]      chk_seed,
  output logic [31:0]       chk_test_size,
  output logic              chk_lfsr_en,
  input  logic              chk_done,
  input  logic              chk_fail,
  input  logic [31:0]       chk_dq_fail,
  output logic              busy,
  output logic              finished,
  output logic              aborted,
  output logic              timeout_err,
  output logic [ITER_W-1:0] iter_count,
  output logic [ITER_W-1:0] fail_count,
  output logic [ITER_W-1:0] first_fail_iter,
  output logic              first_fail_valid,
  output logic [31:0]       dq_fail_accum
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StRun, StResult, StRelease, StDecide, StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_tgt_q, iter_tgt_d;
  logic [31:0]       seed_inc_q, seed_inc_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic              stop_q, stop_d;
  logic              abort_pend_q, abort_pend_d;
  logic              chk_start_q, chk_start_d;
  logic [127:0]      chk_seed_q, chk_seed_d;
  logic [31:0]       chk_test_size_q, chk_test_size_d;
  logic              chk_lfsr_en_q, chk_lfsr_en_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              aborted_q, aborted_d;
  logic              timeout_err_q, timeout_err_d;
  logic [ITER_W-1:0] iter_count_q, iter_count_d;
  logic [ITER_W-1:0] fail_count_q, fail_count_d;
  logic [ITER_W-1:0] first_fail_iter_q, first_fail_iter_d;
  logic              first_fail_valid_q, first_fail_valid_d;
  logic [31:0]       dq_fail_accum_q, dq_fail_accum_d;

  logic              wdog_hit;
  logic              count_done;
  logic              abort_seen;
  logic [ITER_W-1:0] fail_count_sat;

  assign wdog_hit       = (tmo_q != '0) && ((wdog_q + TMO_W'(1)) == tmo_q);
  assign count_done     = (iter_tgt_q != '0) && (iter_count_q == iter_tgt_q);
  assign abort_seen     = abort_pend_q || cfg_abort;
  assign fail_count_sat = (&fail_count_q) ? fail_count_q : fail_count_q + ITER_W'(1);

  always_comb begin
    state_d            = state_q;
    iter_tgt_d         = iter_tgt_q;
    seed_inc_d         = seed_inc_q;
    tmo_d              = tmo_q;
    wdog_d             = wdog_q;
    stop_d             = stop_q;
    abort_pend_d       = abort_pend_q;
    chk_seed_d         = chk_seed_q;
    chk_test_size_d    = chk_test_size_q;
    chk_lfsr_en_d      = chk_lfsr_en_q;
    finished_d         = finished_q;
    aborted_d          = aborted_q;
    timeout_err_d      = timeout_err_q;
    iter_count_d       = iter_count_q;
    fail_count_d       = fail_count_q;
    first_fail_iter_d  = first_fail_iter_q;
    first_fail_valid_d = first_fail_valid_q;
    dq_fail_accum_d    = dq_fail_accum_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_go) begin
          finished_d         = 1'b0;
          aborted_d          = 1'b0;
          timeout_err_d      = 1'b0;
          iter_count_d       = '0;
          fail_count_d       = '0;
          first_fail_iter_d  = '0;
          first_fail_valid_d = 1'b0;
          dq_fail_accum_d    = '0;
          stop_d             = 1'b0;
          abort_pend_d       = 1'b0;
          iter_tgt_d         = cfg_iterations;
          seed_inc_d         = cfg_seed_inc;
          tmo_d              = cfg_timeout;
          chk_seed_d         = cfg_seed;
          chk_test_size_d    = cfg_test_size;
          chk_lfsr_en_d      = cfg_lfsr_en;
          state_d            = StLoad;
        end
      end
      StLoad: begin
        if (cfg_abort) begin
          aborted_d = 1'b1;
          stop_d    = 1'b1;
          state_d   = StRelease;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (cfg_abort) begin
          aborted_d = 1'b1;
          stop_d    = 1'b1;
          state_d   = StRelease;
        end else if (wdog_hit) begin
          timeout_err_d = 1'b1;
          stop_d        = 1'b1;
          fail_count_d  = fail_count_sat;
          state_d       = StRelease;
        end else if (chk_done) begin
          state_d = StResult;
        end
      end
      StResult: begin
        iter_count_d    = iter_count_q + ITER_W'(1);
        dq_fail_accum_d = dq_fail_accum_q | chk_dq_fail;
        if (chk_fail) begin
          fail_count_d = fail_count_sat;
          if (!first_fail_valid_q) begin
            first_fail_iter_d  = iter_count_q;
            first_fail_valid_d = 1'b1;
          end
        end
        if (cfg_abort) abort_pend_d = 1'b1;
        state_d = StRelease;
      end
      StRelease: begin
        if (cfg_abort) abort_pend_d = 1'b1;
        if (wdog_hit) begin
          timeout_err_d = 1'b1;
          stop_d        = 1'b1;
          fail_count_d  = fail_count_sat;
          state_d       = StFinish;
        end else if (!chk_done) begin
          state_d = StDecide;
        end
      end
      StDecide: begin
        if (stop_q || abort_seen) begin
          // Count completion owns the outcome flag when both happen together.
          if (abort_seen && !count_done) aborted_d = 1'b1;
          state_d = StFinish;
        end else if (count_done) begin
          state_d = StFinish;
        end else begin
          chk_seed_d = chk_seed_q + {96'd0, seed_inc_q};
          state_d    = StLoad;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (state_d == StFinish) finished_d = 1'b1;

    // Watchdog restarts on each entry to a wait state.
    if ((state_d == StRun && state_q != StRun) ||
        (state_d == StRelease && state_q != StRelease)) begin
      wdog_d = '0;
    end else if (state_q == StRun || state_q == StRelease) begin
      wdog_d = wdog_q + TMO_W'(1);
    end

    chk_start_d = (state_d == StRun) || (state_d == StResult);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= StIdle;
      iter_tgt_q         <= '0;
      seed_inc_q         <= '0;
      tmo_q              <= '0;
      wdog_q             <= '0;
      stop_q             <= 1'b0;
      abort_pend_q       <= 1'b0;
      chk_start_q        <= 1'b0;
      chk_seed_q         <= '0;
      chk_test_size_q    <= '0;
      chk_lfsr_en_q      <= 1'b0;
      busy_q             <= 1'b0;
      finished_q         <= 1'b0;
      aborted_q          <= 1'b0;
      timeout_err_q      <= 1'b0;
      iter_count_q       <= '0;
      fail_count_q       <= '0;
      first_fail_iter_q  <= '0;
      first_fail_valid_q <= 1'b0;
      dq_fail_accum_q    <= '0;
    end else begin
      state_q            <= state_d;
      iter_tgt_q         <= iter_tgt_d;
      seed_inc_q         <= seed_inc_d;
      tmo_q              <= tmo_d;
      wdog_q             <= wdog_d;
      stop_q             <= stop_d;
      abort_pend_q       <= abort_pend_d;
      chk_start_q        <= chk_start_d;
      chk_seed_q         <= chk_seed_d;
      chk_test_size_q    <= chk_test_size_d;
      chk_lfsr_en_q      <= chk_lfsr_en_d;
      busy_q             <= busy_d;
      finished_q         <= finished_d;
      aborted_q          <= aborted_d;
      timeout_err_q      <= timeout_err_d;
      iter_count_q       <= iter_count_d;
      fail_count_q       <= fail_count_d;
      first_fail_iter_q  <= first_fail_iter_d;
      first_fail_valid_q <= first_fail_valid_d;
      dq_fail_accum_q    <= dq_fail_accum_d;
    end
  end

  assign chk_start        = chk_start_q;
  assign chk_seed         = chk_seed_q;
  assign chk_test_size    = chk_test_size_q;
  assign chk_lfsr_en      = chk_lfsr_en_q;
  assign busy             = busy_q;
  assign finished         = finished_q;
  assign aborted          = aborted_q;
  assign timeout_err      = timeout_err_q;
  assign iter_count       = iter_count_q;
  assign fail_count       = fail_count_q;
  assign first_fail_iter  = first_fail_iter_q;
  assign first_fail_valid = first_fail_valid_q;
  assign dq_fail_accum    = dq_fail_accum_q;

endmodule
